vga_timing_analyzer: RTL and testbench
======================================

# vga_timing_analyzer

Receive-side counterpart of the VGA sync generator. Samples incoming active-high hsync/vsync and measures:
- line period and horizontal sync width in clocks;
- frame height and vertical sync width in lines.

It also recovers per-pixel/per-line position counters and reports lock once timing is stable across consecutive frames. It sits on the capture/monitor path, e.g. looped back from the generator outputs for self-test, or on an external video input.

## Interface
- LOCK_FRAMES, 2: consecutive stable full frames required to assert locked (1..15).
- TIMEOUT, 4000: clocks without an hsync rising edge before signal-loss (≤ 4095).
- clk  in  1  pixel clock.
- reset  in  1  asynchronous, active-high.
- hsync_in  in  1  asynchronous horizontal sync, active-high.
- vsync_in  in  1  asynchronous vertical sync, active-high.
- hcount  out  12  clocks since last detected hsync rising edge, saturating at 4095.
- vcount  out  11  hsync rising edges since last vsync rising edge, saturating at 2047.
- h_total  out  12  measured line period in clocks.
- h_sync_width  out  12  measured hsync high time in clocks.
- v_total  out  11  measured frame height in lines.
- v_sync_width  out  11  measured vsync high time in lines.
- frame_start  out  1  one-clock pulse on each detected vsync rising edge.
- locked  out  1  timing stable for LOCK_FRAMES frames.
- no_signal  out  1  high while hsync is absent.

## Operation
- **Input conditioning:** each sync goes through a 2-flop synchronizer plus a history flop. Rise/fall strobes are s2 & ~s3 / ~s2 & s3.
- **Horizontal timing:**
  - hsync rise: h_total <= hcount+1, hcount <= 0.
  - hsync fall: h_sync_width <= hcount+1.
  - Otherwise hcount increments, saturating at 4095.
- **Vertical timing:**
  - hsync rise (no vsync rise in the same cycle): vcount++, saturating.
  - vsync rise: v_total <= vcount, vcount <= (hsync rise same cycle ? 1 : 0), frame_start <= 1. A coincident hsync edge belongs to the new frame.
  - vsync fall: v_sync_width <= vcount + (hsync rise same cycle ? 1 : 0).
- **FSM:**
  - **SEARCH** (reset state): h_valid sets on the second hsync rise. A vsync rise with h_valid → ACQUIRE, stable <= 1, lock_cnt <= 0, first_full <= 1. The partial frame is ignored.
  - **ACQUIRE:**
    - Any hsync rise whose new h_total ≠ current h_total clears stable.
    - On vsync rise, the frame passes if stable && (first_full || new v_total == current v_total). Pass → lock_cnt++; fail → lock_cnt <= 0. Then stable <= 1, first_full <= 0.
    - lock_cnt reaching LOCK_FRAMES → LOCKED.
  - **LOCKED:**
    - h_total mismatch → ACQUIRE, lock_cnt <= 0, stable <= 0.
    - v_total mismatch at a vsync rise → ACQUIRE, lock_cnt <= 0, stable <= 1.
- **Signal loss:**
  - Trigger: hcount == TIMEOUT-1 with no hsync rise.
  - Effect: all measurement outputs <= 0, h_valid <= 0, locked <= 0, state <= SEARCH, no_signal <= 1.
  - Recovery: next hsync rise clears no_signal.
- **locked:** registered, equal to (state == LOCKED).

## Timing
- Reset values: hcount, vcount, h_total, h_sync_width, v_total, v_sync_width, frame_start, locked all 0. no_signal = 1. FSM in SEARCH.
- **Edge latency:** with input first sampled high at clock edge k, the strobe is valid between k+1 and k+2. All strobe-driven register updates occur at edge k+2; the update is visible after k+2.
- **Lock timing:** for a clean source, locked rises 2 clocks after the vsync rise that completes the LOCK_FRAMES-th full frame. That is the (LOCK_FRAMES+1)-th vsync rise after SEARCH exit.
- locked falls at the same edge that writes the mismatching h_total/v_total.
- **Timeout:** signal loss is declared exactly TIMEOUT clocks after the last hsync rise strobe.
- Reset asserted mid-frame returns everything to reset values immediately, without waiting for a clock.

## Test plan
- **Nominal lock:** generator timing 800-clock line, 95-clock hsync, 525 lines, 2-line vsync → h_total=800, h_sync_width=95, v_total=525, v_sync_width=2. locked=1 at the 3rd vsync rise +2 clocks. frame_start pulses once per 525×800 clocks.
- **Line glitch:** one line shortened to 799 clocks while locked → locked=0 at that update, h_total=799. Relock after 2 further clean full frames.
- **Frame-height change:** 525→526 lines while locked → locked=0 at the vsync rise with v_total=526. locked=1 two frames later.
- **Signal loss:** hsync stopped → exactly 4000 clocks after the last rise, all measurements 0, no_signal=1, locked=0. Restart → no_signal=0 at the first rise, full reacquire.
- **Coincident edges:** vsync rise in the same clock as hsync rise → vcount=1 afterwards, v_total unchanged relative to the non-coincident case.
- **Async reset mid-frame:** outputs are at reset values immediately. The bench enables hsync/vsync sometime after reset deassertion; no lock until SEARCH→ACQUIRE completes.

Source files
------------

// File: rtl/vga_timing_analyzer_if.sv
// Sync inputs and timing measurements of the VGA timing analyzer.
// The slave side is the analyzer; the master side drives the syncs and observes the results.
interface vga_timing_analyzer_if;
  logic        hsync_in;
  logic        vsync_in;
  logic [11:0] hcount;
  logic [10:0] vcount;
  logic [11:0] h_total;
  logic [11:0] h_sync_width;
  logic [10:0] v_total;
  logic [10:0] v_sync_width;
  logic        frame_start;
  logic        locked;
  logic        no_signal;

  modport master (
    output hsync_in, vsync_in,
    input  hcount, vcount, h_total, h_sync_width, v_total, v_sync_width,
    input  frame_start, locked, no_signal
  );

  modport slave (
    input  hsync_in, vsync_in,
    output hcount, vcount, h_total, h_sync_width, v_total, v_sync_width,
    output frame_start, locked, no_signal
  );
endinterface

// File: rtl/vga_timing_analyzer.sv
// Receive-side VGA timing analyzer: measures line/frame timing from incoming
// hsync/vsync, recovers position counters, and reports lock and signal loss.
module vga_timing_analyzer #(
  parameter int unsigned LOCK_FRAMES = 2,
  parameter int unsigned TIMEOUT     = 4000
) (
  input  logic                  clk,
  input  logic                  reset,
  vga_timing_analyzer_if.slave  vid
);

  typedef enum logic [1:0] {SEARCH, ACQUIRE, LOCKED} state_t;

  localparam logic [11:0] TIMEOUT_LAST = 12'(TIMEOUT - 1);
  localparam logic [4:0]  LOCK_TARGET  = 5'(LOCK_FRAMES);

  logic [2:0]  h_pipe, v_pipe;
  logic        h_rise, h_fall, v_rise, v_fall;
  logic [11:0] hcount, h_total, h_sync_width, h_meas;
  logic [10:0] vcount, v_total, v_sync_width, v_width_meas;
  logic        frame_start, locked, no_signal;
  logic        h_seen, h_valid, stable, first_full;
  logic [3:0]  lock_cnt;
  logic        loss, h_mismatch, v_mismatch, frame_pass;
  state_t      state, state_next;

  // Bit 0/1 form the synchronizer, bit 2 is the history flop for edge detection.
  assign h_rise = h_pipe[1] & ~h_pipe[2];
  assign h_fall = ~h_pipe[1] & h_pipe[2];
  assign v_rise = v_pipe[1] & ~v_pipe[2];
  assign v_fall = ~v_pipe[1] & v_pipe[2];

  // Length measured up to and including the current clock, saturating.
  assign h_meas       = (hcount == 12'hFFF) ? 12'hFFF : hcount + 12'd1;
  // A coincident hsync rise at the vsync fall still counts toward the sync width.
  assign v_width_meas = (h_rise && vcount != 11'h7FF) ? vcount + 11'd1 : vcount;

  assign loss       = (hcount == TIMEOUT_LAST) && !h_rise;
  assign h_mismatch = h_rise && (h_meas != h_total);
  assign v_mismatch = v_rise && (vcount != v_total);
  assign frame_pass = stable && (first_full || !v_mismatch);

  // Synchronize both sync inputs into the clock domain and keep one bit of history.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      h_pipe <= '0;
      v_pipe <= '0;
    end else begin
      h_pipe <= {h_pipe[1:0], vid.hsync_in};
      v_pipe <= {v_pipe[1:0], vid.vsync_in};
    end
  end

  // Horizontal position counter plus line period and hsync width capture.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hcount       <= '0;
      h_total      <= '0;
      h_sync_width <= '0;
    end else begin
      if (h_rise)                hcount <= '0;
      else if (hcount != 12'hFFF) hcount <= hcount + 12'd1;
      if (loss) begin
        h_total      <= '0;
        h_sync_width <= '0;
      end else begin
        if (h_rise) h_total      <= h_meas;
        if (h_fall) h_sync_width <= h_meas;
      end
    end
  end

  // Line counter plus frame height and vsync width capture; a coincident hsync edge opens the new frame.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vcount       <= '0;
      v_total      <= '0;
      v_sync_width <= '0;
      frame_start  <= 1'b0;
    end else begin
      frame_start <= v_rise;
      if (v_rise)                          vcount <= h_rise ? 11'd1 : 11'd0;
      else if (h_rise && vcount != 11'h7FF) vcount <= vcount + 11'd1;
      if (loss) begin
        v_total      <= '0;
        v_sync_width <= '0;
      end else begin
        if (v_rise) v_total      <= vcount;
        if (v_fall) v_sync_width <= v_width_meas;
      end
    end
  end

  // Track hsync presence; a valid line period needs two rises after (re)start.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      no_signal <= 1'b1;
      h_seen    <= 1'b0;
      h_valid   <= 1'b0;
    end else if (loss) begin
      no_signal <= 1'b1;
      h_seen    <= 1'b0;
      h_valid   <= 1'b0;
    end else if (h_rise) begin
      no_signal <= 1'b0;
      h_seen    <= 1'b1;
      if (h_seen) h_valid <= 1'b1;
    end
  end

  // Lock state register; locked follows the next state so it moves on the same edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= SEARCH;
      locked <= 1'b0;
    end else begin
      state  <= state_next;
      locked <= (state_next == LOCKED);
    end
  end

  // Next-state logic; signal loss forces a return to SEARCH from anywhere.
  always_comb begin
    state_next = state;
    case (state)
      SEARCH:  if (v_rise && h_valid) state_next = ACQUIRE;
      ACQUIRE: if (v_rise && frame_pass && ({1'b0, lock_cnt} + 5'd1 >= LOCK_TARGET))
                 state_next = LOCKED;
      LOCKED:  if (h_mismatch || v_mismatch) state_next = ACQUIRE;
      default: state_next = SEARCH;
    endcase
    if (loss) state_next = SEARCH;
  end

  // Frame qualification bookkeeping: stability within a frame and count of good frames.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stable     <= 1'b0;
      first_full <= 1'b0;
      lock_cnt   <= '0;
    end else begin
      case (state)
        SEARCH: begin
          if (v_rise && h_valid) begin
            stable     <= 1'b1;
            first_full <= 1'b1;
            lock_cnt   <= '0;
          end
        end
        ACQUIRE: begin
          if (v_rise) begin
            lock_cnt   <= frame_pass ? lock_cnt + 4'd1 : 4'd0;
            stable     <= 1'b1;
            first_full <= 1'b0;
          end else if (h_mismatch) begin
            stable <= 1'b0;
          end
        end
        LOCKED: begin
          if (h_mismatch || v_mismatch) begin
            lock_cnt <= '0;
            stable   <= v_rise;
          end
        end
        default: ;
      endcase
    end
  end

  assign vid.hcount       = hcount;
  assign vid.vcount       = vcount;
  assign vid.h_total      = h_total;
  assign vid.h_sync_width = h_sync_width;
  assign vid.v_total      = v_total;
  assign vid.v_sync_width = v_sync_width;
  assign vid.frame_start  = frame_start;
  assign vid.locked       = locked;
  assign vid.no_signal    = no_signal;

endmodule

// File: tb/tb_vga_timing_analyzer.sv
// Directed scoreboard bench for vga_timing_analyzer using a scaled-down sync generator
// (64-clock lines, 8-clock hsync, 20 lines, 2-line vsync).
module tb_vga_timing_analyzer;

  localparam int LEN   = 64;
  localparam int HS    = 8;
  localparam int VSL   = 2;
  localparam int LINES = 20;
  localparam int VOFF  = 10;

  typedef enum {SEL_HCOUNT, SEL_VCOUNT, SEL_HTOTAL, SEL_HSW, SEL_VTOTAL,
                SEL_VSW, SEL_FS, SEL_LOCKED, SEL_NOSIG} sel_t;

  typedef struct {
    string       tag;
    sel_t        sel;
    logic [31:0] value;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];

  int gl, gx, g_lines, g_vs_off, glitch_line;
  bit g_run;

  vga_timing_analyzer_if vid();

  vga_timing_analyzer #(.LOCK_FRAMES(2), .TIMEOUT(4000)) dut (
    .clk   (clk),
    .reset (reset),
    .vid   (vid)
  );

  // Pixel clock.
  always #5 clk = ~clk;

  // Safety net in case the sequence stalls.
  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [31:0] read_sel(input sel_t s);
    logic [31:0] r;
    r = 'x;
    case (s)
      SEL_HCOUNT: r = 32'(vid.hcount);
      SEL_VCOUNT: r = 32'(vid.vcount);
      SEL_HTOTAL: r = 32'(vid.h_total);
      SEL_HSW:    r = 32'(vid.h_sync_width);
      SEL_VTOTAL: r = 32'(vid.v_total);
      SEL_VSW:    r = 32'(vid.v_sync_width);
      SEL_FS:     r = 32'(vid.frame_start);
      SEL_LOCKED: r = 32'(vid.locked);
      SEL_NOSIG:  r = 32'(vid.no_signal);
      default:    r = 'x;
    endcase
    return r;
  endfunction

  task automatic expect_val(input string tag, input sel_t sel, input logic [31:0] value);
    exp_t e;
    e.tag   = tag;
    e.sel   = sel;
    e.value = value;
    exp_q.push_back(e);
  endtask

  task automatic expect_reset();
    expect_val("rst_hcount", SEL_HCOUNT, 0);
    expect_val("rst_vcount", SEL_VCOUNT, 0);
    expect_val("rst_h_total", SEL_HTOTAL, 0);
    expect_val("rst_h_sync_width", SEL_HSW, 0);
    expect_val("rst_v_total", SEL_VTOTAL, 0);
    expect_val("rst_v_sync_width", SEL_VSW, 0);
    expect_val("rst_frame_start", SEL_FS, 0);
    expect_val("rst_locked", SEL_LOCKED, 0);
    expect_val("rst_no_signal", SEL_NOSIG, 1);
  endtask

  task automatic checkOutput();
    exp_t        e;
    logic [31:0] obs;
    while (exp_q.size() > 0) begin
      e   = exp_q.pop_front();
      obs = read_sel(e.sel);
      checks++;
      assert (obs === e.value) else begin
        errors++;
        $error("[TB] FAIL %s: observed=%0d expected=%0d", e.tag, obs, e.value);
      end
    end
  endtask

  // One generator clock: drive the syncs for position (gl, gx) at the falling edge, then advance.
  task automatic step_gen();
    int cur_len;
    @(negedge clk);
    cur_len = (gl == glitch_line) ? LEN - 1 : LEN;
    if (g_run) begin
      vid.hsync_in = (gx < HS);
      vid.vsync_in = (gl == 0 && gx >= g_vs_off) || (gl > 0 && gl < VSL) ||
                     (gl == VSL && gx < g_vs_off);
    end else begin
      vid.hsync_in = 1'b0;
      vid.vsync_in = 1'b0;
    end
    gx++;
    if (gx >= cur_len) begin
      gx = 0;
      if (gl == glitch_line) glitch_line = -1;
      gl++;
      if (gl >= g_lines) gl = 0;
    end
  endtask

  task automatic applyStimulus(input int n);
    repeat (n) step_gen();
  endtask

  // Run until position (l, x) is the next to be driven, then drive it.
  task automatic to_point(input int l, input int x);
    int guard;
    bit expired;
    guard   = 0;
    expired = 1'b0;
    while (!(gl == l && gx == x) && !expired) begin
      step_gen();
      guard++;
      if (guard > 3000) expired = 1'b1;
    end
    if (expired) begin
      checks++;
      errors++;
      $display("[TB] FAIL to_point(%0d,%0d): observed=not reached expected=reached", l, x);
    end
    step_gen();
  endtask

  // Main directed sequence.
  initial begin
    reset        = 1'b1;
    vid.hsync_in = 1'b0;
    vid.vsync_in = 1'b0;
    g_run        = 1'b0;
    gl           = 3;
    gx           = 0;
    g_lines      = LINES;
    g_vs_off     = VOFF;
    glitch_line  = -1;

    @(negedge clk);
    expect_reset();
    checkOutput();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);

    $display("[TB] nominal acquisition");
    g_run = 1'b1;
    to_point(0, VOFF);
    applyStimulus(3);
    expect_val("v1_frame_start", SEL_FS, 1);
    expect_val("v1_locked", SEL_LOCKED, 0);
    expect_val("v1_no_signal", SEL_NOSIG, 0);
    expect_val("v1_h_total", SEL_HTOTAL, LEN);
    expect_val("v1_h_sync_width", SEL_HSW, HS);
    expect_val("v1_partial_v_total", SEL_VTOTAL, LINES - 3 + 1);
    checkOutput();
    applyStimulus(1);
    expect_val("v1_frame_start_end", SEL_FS, 0);
    checkOutput();

    to_point(0, VOFF);
    applyStimulus(3);
    expect_val("v2_v_total", SEL_VTOTAL, LINES);
    expect_val("v2_v_sync_width", SEL_VSW, VSL);
    expect_val("v2_locked", SEL_LOCKED, 0);
    expect_val("v2_vcount", SEL_VCOUNT, 0);
    expect_val("v2_hcount", SEL_HCOUNT, VOFF);
    checkOutput();

    to_point(0, VOFF);
    applyStimulus(2);
    expect_val("v3_locked_early", SEL_LOCKED, 0);
    checkOutput();
    applyStimulus(1);
    expect_val("v3_locked", SEL_LOCKED, 1);
    expect_val("v3_frame_start", SEL_FS, 1);
    checkOutput();

    $display("[TB] line glitch");
    glitch_line = 5;
    to_point(6, 0);
    applyStimulus(2);
    expect_val("gl_locked_before", SEL_LOCKED, 1);
    expect_val("gl_h_total_before", SEL_HTOTAL, LEN);
    checkOutput();
    applyStimulus(1);
    expect_val("gl_locked_drop", SEL_LOCKED, 0);
    expect_val("gl_h_total_short", SEL_HTOTAL, LEN - 1);
    checkOutput();
    to_point(0, VOFF);
    applyStimulus(3);
    expect_val("gl_f0_locked", SEL_LOCKED, 0);
    expect_val("gl_f0_h_total", SEL_HTOTAL, LEN);
    expect_val("gl_f0_v_total", SEL_VTOTAL, LINES);
    checkOutput();
    to_point(0, VOFF);
    applyStimulus(3);
    expect_val("gl_f1_locked", SEL_LOCKED, 0);
    checkOutput();
    to_point(0, VOFF);
    applyStimulus(2);
    expect_val("gl_f2_locked_early", SEL_LOCKED, 0);
    checkOutput();
    applyStimulus(1);
    expect_val("gl_f2_relocked", SEL_LOCKED, 1);
    checkOutput();

    $display("[TB] frame height change");
    g_lines = LINES + 1;
    to_point(0, VOFF);
    applyStimulus(2);
    expect_val("fh_locked_before", SEL_LOCKED, 1);
    checkOutput();
    applyStimulus(1);
    expect_val("fh_locked_drop", SEL_LOCKED, 0);
    expect_val("fh_v_total", SEL_VTOTAL, LINES + 1);
    checkOutput();
    to_point(0, VOFF);
    applyStimulus(3);
    expect_val("fh_f1_locked", SEL_LOCKED, 0);
    checkOutput();
    to_point(0, VOFF);
    applyStimulus(2);
    expect_val("fh_f2_locked_early", SEL_LOCKED, 0);
    checkOutput();
    applyStimulus(1);
    expect_val("fh_f2_relocked", SEL_LOCKED, 1);
    checkOutput();

    $display("[TB] coincident hsync/vsync edges");
    g_vs_off = 0;
    to_point(0, 0);
    applyStimulus(3);
    expect_val("co1_vcount", SEL_VCOUNT, 1);
    expect_val("co1_hcount", SEL_HCOUNT, 0);
    expect_val("co1_frame_start", SEL_FS, 1);
    expect_val("co1_h_total", SEL_HTOTAL, LEN);
    expect_val("co1_v_total", SEL_VTOTAL, LINES);
    checkOutput();
    to_point(0, 0);
    applyStimulus(3);
    expect_val("co2_v_total", SEL_VTOTAL, LINES + 1);
    expect_val("co2_vcount", SEL_VCOUNT, 1);
    checkOutput();
    to_point(0, 0);
    to_point(0, 0);
    applyStimulus(3);
    expect_val("co4_locked", SEL_LOCKED, 1);
    checkOutput();

    $display("[TB] signal loss");
    to_point(3, 0);
    g_run = 1'b0;
    applyStimulus(4002);
    expect_val("ls_no_signal_before", SEL_NOSIG, 0);
    expect_val("ls_locked_before", SEL_LOCKED, 1);
    expect_val("ls_h_total_before", SEL_HTOTAL, LEN);
    expect_val("ls_hcount_before", SEL_HCOUNT, 3999);
    checkOutput();
    applyStimulus(1);
    expect_val("ls_no_signal", SEL_NOSIG, 1);
    expect_val("ls_locked", SEL_LOCKED, 0);
    expect_val("ls_h_total", SEL_HTOTAL, 0);
    expect_val("ls_h_sync_width", SEL_HSW, 0);
    expect_val("ls_v_total", SEL_VTOTAL, 0);
    expect_val("ls_v_sync_width", SEL_VSW, 0);
    checkOutput();

    $display("[TB] restart after loss");
    g_lines  = LINES;
    g_vs_off = VOFF;
    gl       = 3;
    gx       = 0;
    g_run    = 1'b1;
    applyStimulus(3);
    expect_val("rs_no_signal_hold", SEL_NOSIG, 1);
    checkOutput();
    applyStimulus(1);
    expect_val("rs_no_signal_clear", SEL_NOSIG, 0);
    checkOutput();
    to_point(0, VOFF);
    applyStimulus(3);
    expect_val("rs_f0_locked", SEL_LOCKED, 0);
    expect_val("rs_f0_h_total", SEL_HTOTAL, LEN);
    checkOutput();
    to_point(0, VOFF);
    applyStimulus(3);
    expect_val("rs_f1_locked", SEL_LOCKED, 0);
    expect_val("rs_f1_v_total", SEL_VTOTAL, LINES);
    checkOutput();
    to_point(0, VOFF);
    applyStimulus(2);
    expect_val("rs_f2_locked_early", SEL_LOCKED, 0);
    checkOutput();
    applyStimulus(1);
    expect_val("rs_f2_locked", SEL_LOCKED, 1);
    checkOutput();

    $display("[TB] asynchronous reset mid-frame");
    to_point(5, 20);
    #2;
    reset = 1'b1;
    #1;
    expect_reset();
    checkOutput();
    repeat (3) @(negedge clk);
    reset        = 1'b0;
    vid.hsync_in = 1'b0;
    vid.vsync_in = 1'b0;
    repeat (20) @(negedge clk);
    gl = 3;
    gx = 0;
    to_point(0, VOFF);
    applyStimulus(3);
    expect_val("ar_f0_locked", SEL_LOCKED, 0);
    expect_val("ar_f0_frame_start", SEL_FS, 1);
    checkOutput();
    to_point(0, VOFF);
    applyStimulus(3);
    expect_val("ar_f1_locked", SEL_LOCKED, 0);
    checkOutput();
    to_point(0, VOFF);
    applyStimulus(2);
    expect_val("ar_f2_locked_early", SEL_LOCKED, 0);
    checkOutput();
    applyStimulus(1);
    expect_val("ar_f2_locked", SEL_LOCKED, 1);
    checkOutput();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
